direction_vote_filter: RTL and testbench
========================================

# direction_vote_filter

Temporal smoother that sits directly downstream of the localizer. It consumes the 4-bit direction bin emitted once per FFT frame and keeps a sliding window of the last DEPTH bins with a per-bin histogram. It applies majority voting with hysteresis so that single-frame outliers do not move the reported direction. It publishes a stable bin, a confidence count and a change pulse for the actuator and debug logic.

## Interface
Parameters:
- DEPTH, 8: window length in frames; legal range 2..15.
- NUM_BINS, 16: number of direction bins; bin_in values ≥ NUM_BINS are illegal.
- HYST, 2: margin by which a challenger's count must exceed the held bin's count before the output switches; legal range 0..DEPTH.

Ports (CW = $clog2(DEPTH+1)):
- clk_in  input  1  system clock; single clock domain.
- rst_n_in  input  1  asynchronous, active-low reset.
- bin_in  input  4  direction bin from the localizer.
- bin_valid_in  input  1  one-cycle pulse qualifying bin_in.
- ready_out  output  1  high only in IDLE; a bin is accepted on a rising edge where bin_valid_in && ready_out.
- bin_out  output  4  held (filtered) direction bin.
- bin_valid_out  output  1  one-cycle pulse per completed decision.
- changed_out  output  1  one-cycle pulse, coincident with bin_valid_out, when bin_out took a new value.
- confidence_out  output  CW  histogram count of the held bin after the decision (0..DEPTH).
- window_full_out  output  1  the window holds DEPTH entries.
- overrun_out  output  1  sticky flag; set when bin_valid_in arrives while ready_out=0.

## Operation
- Storage:
  - Circular buffer buf[DEPTH] of 4-bit entries, indexed by write pointer wr_ptr, which wraps DEPTH-1→0.
  - fill counter, saturating at DEPTH.
  - hist[NUM_BINS], each CW bits.
  - held_valid flag.
- FSM states: IDLE → UPDATE → SCAN → DECIDE → IDLE.
- IDLE: ready_out=1. On accept, latch bin_in into new_bin and go to UPDATE.
- UPDATE (1 cycle):
  - If fill==DEPTH, decrement hist[buf[wr_ptr]].
  - Increment hist[new_bin].
  - If the evicted bin equals new_bin, the net count change is zero; hist must never transiently exceed DEPTH or underflow.
  - Write buf[wr_ptr]=new_bin, advance wr_ptr, saturate fill.
- SCAN (NUM_BINS cycles):
  - Visit one bin index per cycle, 0..NUM_BINS-1.
  - Track max_cnt and cand, updating only on a strictly greater count, so ties go to the lowest index.
- DECIDE (1 cycle):
  - If !held_valid, or max_cnt ≥ hist[held] + HYST with cand ≠ held, then held ← cand and changed_out is pulsed.
  - Otherwise held is unchanged.
  - Register bin_out=held and confidence_out=hist[held]; pulse bin_valid_out; set held_valid.
  - Return to IDLE.
- window_full_out = (fill==DEPTH), updated with fill.
- overrun_out is set on any cycle with bin_valid_in && !ready_out. Only reset clears it. The dropped bin is not queued and does not touch hist.
- Arithmetic rules: comparisons are unsigned and use CW+1-bit sums, so hist[held]+HYST cannot overflow.

## Timing
- Reset (async assert, synchronous-to-clk release):
  - state=IDLE; ready_out=1; hist, buf, wr_ptr and fill all 0.
  - bin_out=0, confidence_out=0, bin_valid_out=0, changed_out=0, window_full_out=0, overrun_out=0, held_valid=0.
  - Inputs are ignored while rst_n_in=0.
- Latency:
  - Accept edge E0. UPDATE completes at E1; SCAN occupies E1..E(NUM_BINS); DECIDE registers outputs at E(NUM_BINS+1).
  - bin_valid_out is high during the cycle after E(NUM_BINS+1): 17 cycles after acceptance with defaults.
  - ready_out returns high in that same cycle, so the earliest next accept is at E(NUM_BINS+2). Minimum input spacing is NUM_BINS+2 cycles; this is far below one FFT frame.
- All outputs are registered. bin_out and confidence_out hold their value between decisions.
- Reset mid-operation: any state aborts to IDLE with reset values, and no bin_valid_out is issued for the in-flight bin.

## Test plan
- Reset: hold rst_n_in low mid-sim → all outputs at the reset values above, ready_out=1, and bin_valid_in pulses are ignored.
- Fill and latency: feed 8 bins of value 5 with a spacing of 40 cycles.
  - First decision: bin_valid_out exactly 17 cycles after the accept edge; bin_out=5, confidence_out=1, changed_out=1.
  - 8th decision: confidence_out=8, window_full_out=1, changed_out=0.
- Hysteresis: continuing from the full window of 5s, feed bin 3 repeatedly (wrap-around eviction).
  - Frames 1–4: bin_out stays 5, and confidence_out goes 7,6,5,4.
  - Frame 5 (3 has 5 counts, 5 has 3): bin_out=3, confidence_out=5, changed_out=1.
- Tie handling: after reset, feed 9 then 2.
  - First decision: bin_out=9.
  - Second decision: counts tie at 1, so cand=2 but HYST is not met; bin_out stays 9 and changed_out=0.
- Overrun: 3 cycles after an accept, pulse bin_valid_in=1 with bin_in=7.
  - Required: overrun_out=1 and stays 1.
  - Next decision: confidence_out and bin_out unaffected; hist[7]=0 (via a later probe sequence).
- Reset mid-SCAN: assert rst_n_in low 5 cycles after an accept → no bin_valid_out pulse and reset values restored. The next accepted bin 4 produces bin_out=4, confidence_out=1, changed_out=1.

Source files
------------

// File: rtl/direction_vote_filter.sv
// direction_vote_filter
// Temporal smoother for the localizer's per-frame direction bin. Keeps a
// sliding window of the last DEPTH bins with a per-bin histogram, then picks
// the majority bin with hysteresis so single-frame outliers cannot move the
// reported direction.
//
// Ports:
//   clk_in          system clock
//   rst_n_in        asynchronous active-low reset
//   bin_in          direction bin from the localizer (must be < NUM_BINS)
//   bin_valid_in    one-cycle pulse qualifying bin_in
//   ready_out       high while idle; bin accepted when bin_valid_in && ready_out
//   bin_out         held (filtered) direction bin
//   bin_valid_out   one-cycle pulse per completed decision
//   changed_out     one-cycle pulse with bin_valid_out when bin_out changed
//   confidence_out  histogram count of the held bin after the decision
//   window_full_out window holds DEPTH entries
//   overrun_out     sticky: a bin arrived while busy and was dropped
module direction_vote_filter #(
  parameter int DEPTH    = 8,
  parameter int NUM_BINS = 16,
  parameter int HYST     = 2,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic [3:0]    bin_in,
  input  logic          bin_valid_in,
  output logic          ready_out,
  output logic [3:0]    bin_out,
  output logic          bin_valid_out,
  output logic          changed_out,
  output logic [CW-1:0] confidence_out,
  output logic          window_full_out,
  output logic          overrun_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [3:0]    LAST_BIN = 4'(NUM_BINS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   HYST_C   = (CW + 1)'(HYST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SCAN   = 2'd2,
    ST_DECIDE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    new_bin_q, new_bin_d;
  logic [3:0]    win_buf_q [DEPTH];
  logic [3:0]    win_buf_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] hist_q [NUM_BINS];
  logic [CW-1:0] hist_d [NUM_BINS];
  logic [3:0]    held_q, held_d;
  logic          held_valid_q, held_valid_d;
  logic [SW-1:0] scan_idx_q, scan_idx_d;
  logic [CW-1:0] max_cnt_q, max_cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic          ready_q, ready_d;
  logic [3:0]    bin_out_q, bin_out_d;
  logic          bin_valid_q, bin_valid_d;
  logic          changed_q, changed_d;
  logic [CW-1:0] confidence_q, confidence_d;
  logic          window_full_q, window_full_d;
  logic          overrun_q, overrun_d;

  // Combinational helpers shared by the next-state logic.
  logic [3:0]    evict_bin_s;
  logic          full_s;
  logic [CW-1:0] fin_max_s;
  logic [3:0]    fin_cand_s;
  logic [CW:0]   held_thr_s;

  // Next-state, datapath and output computation for the vote FSM.
  always_comb begin
    state_d       = state_q;
    new_bin_d     = new_bin_q;
    win_buf_d     = win_buf_q;
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    hist_d        = hist_q;
    held_d        = held_q;
    held_valid_d  = held_valid_q;
    scan_idx_d    = scan_idx_q;
    max_cnt_d     = max_cnt_q;
    cand_d        = cand_q;
    bin_out_d     = bin_out_q;
    bin_valid_d   = 1'b0;
    changed_d     = 1'b0;
    confidence_d  = confidence_q;
    overrun_d     = overrun_q;

    evict_bin_s   = win_buf_q[wr_ptr_q];
    full_s        = (fill_q == DEPTH_C);
    fin_max_s     = max_cnt_q;
    fin_cand_s    = cand_q;
    held_thr_s    = {1'b0, hist_q[held_q]} + HYST_C;

    if (bin_valid_in && !ready_q) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bin_valid_in && ready_q) begin
          new_bin_d = bin_in;
          state_d   = ST_UPDATE;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_UPDATE: begin
        // Evicting the same bin being inserted is a net no-op, so skip both
        // edits rather than letting the count pass through DEPTH+1.
        if (full_s && (evict_bin_s != new_bin_q)) begin
          hist_d[evict_bin_s] = hist_q[evict_bin_s] - CW'(1);
          hist_d[new_bin_q]   = hist_q[new_bin_q] + CW'(1);
        end else if (!full_s) begin
          hist_d[new_bin_q]   = hist_q[new_bin_q] + CW'(1);
        end else begin
          hist_d = hist_q;
        end
        win_buf_d[wr_ptr_q] = new_bin_q;
        if (wr_ptr_q == PW'(DEPTH - 1)) begin
          wr_ptr_d = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (!full_s) begin
          fill_d = fill_q + CW'(1);
        end else begin
          fill_d = fill_q;
        end
        scan_idx_d = '0;
        max_cnt_d  = '0;
        cand_d     = 4'd0;
        state_d    = ST_SCAN;
      end

      ST_SCAN: begin
        // Strictly-greater update keeps ties on the lowest index. The last
        // bin is folded in during DECIDE so the decision lands one cycle
        // earlier.
        if (hist_q[scan_idx_q] > max_cnt_q) begin
          max_cnt_d = hist_q[scan_idx_q];
          cand_d    = 4'(scan_idx_q);
        end else begin
          max_cnt_d = max_cnt_q;
        end
        if (scan_idx_q >= SW'(NUM_BINS - 2)) begin
          state_d = ST_DECIDE;
        end else begin
          scan_idx_d = scan_idx_q + SW'(1);
        end
      end

      ST_DECIDE: begin
        if (hist_q[LAST_BIN] > max_cnt_q) begin
          fin_max_s  = hist_q[LAST_BIN];
          fin_cand_s = LAST_BIN;
        end else begin
          fin_max_s  = max_cnt_q;
        end
        if (!held_valid_q ||
            ((fin_cand_s != held_q) && ({1'b0, fin_max_s} >= held_thr_s))) begin
          held_d    = fin_cand_s;
          changed_d = 1'b1;
        end else begin
          held_d    = held_q;
        end
        bin_out_d    = held_d;
        confidence_d = hist_q[held_d];
        bin_valid_d  = 1'b1;
        held_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d       = (state_d == ST_IDLE);
    window_full_d = (fill_d == DEPTH_C);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_IDLE;
      new_bin_q     <= 4'd0;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      held_q        <= 4'd0;
      held_valid_q  <= 1'b0;
      scan_idx_q    <= '0;
      max_cnt_q     <= '0;
      cand_q        <= 4'd0;
      ready_q       <= 1'b1;
      bin_out_q     <= 4'd0;
      bin_valid_q   <= 1'b0;
      changed_q     <= 1'b0;
      confidence_q  <= '0;
      window_full_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        win_buf_q[i] <= 4'd0;
      end
      for (int i = 0; i < NUM_BINS; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      new_bin_q     <= new_bin_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
      held_q        <= held_d;
      held_valid_q  <= held_valid_d;
      scan_idx_q    <= scan_idx_d;
      max_cnt_q     <= max_cnt_d;
      cand_q        <= cand_d;
      ready_q       <= ready_d;
      bin_out_q     <= bin_out_d;
      bin_valid_q   <= bin_valid_d;
      changed_q     <= changed_d;
      confidence_q  <= confidence_d;
      window_full_q <= window_full_d;
      overrun_q     <= overrun_d;
      win_buf_q     <= win_buf_d;
      hist_q        <= hist_d;
    end
  end

  assign ready_out       = ready_q;
  assign bin_out         = bin_out_q;
  assign bin_valid_out   = bin_valid_q;
  assign changed_out     = changed_q;
  assign confidence_out  = confidence_q;
  assign window_full_out = window_full_q;
  assign overrun_out     = overrun_q;

endmodule

// File: tb/tb_direction_vote_filter.sv
// Self-checking bench for direction_vote_filter (default parameters).
module tb_direction_vote_filter;

  localparam int DEPTH    = 8;
  localparam int NUM_BINS = 16;
  localparam int HYST     = 2;
  localparam int CW       = 4;
  localparam int LAT      = NUM_BINS + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    bin_in = 4'd0;
  logic          bin_valid_in = 1'b0;
  logic          ready_out;
  logic [3:0]    bin_out;
  logic          bin_valid_out;
  logic          changed_out;
  logic [CW-1:0] confidence_out;
  logic          window_full_out;
  logic          overrun_out;

  int checks = 0;
  int errors = 0;

  // Reference model: window as a queue, counts recomputed from scratch.
  int q[$];
  int m_held;
  bit m_hv;

  typedef struct {
    int bin;
    int e_bin;
    int e_conf;
    int e_chg;
    int e_full;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  direction_vote_filter #(.DEPTH(DEPTH), .NUM_BINS(NUM_BINS), .HYST(HYST)) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bin_in(bin_in),
    .bin_valid_in(bin_valid_in),
    .ready_out(ready_out),
    .bin_out(bin_out),
    .bin_valid_out(bin_valid_out),
    .changed_out(changed_out),
    .confidence_out(confidence_out),
    .window_full_out(window_full_out),
    .overrun_out(overrun_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_held = 0;
    m_hv   = 1'b0;
  endtask

  task automatic model_step(input int b, output int eb, output int ec,
                            output int ech, output int ef);
    int cnt[NUM_BINS];
    int mx, cand;
    q.push_back(b);
    if (q.size() > DEPTH) void'(q.pop_front());
    for (int i = 0; i < NUM_BINS; i++) cnt[i] = 0;
    foreach (q[i]) cnt[q[i]]++;
    mx = -1;
    cand = 0;
    for (int i = 0; i < NUM_BINS; i++) begin
      if (cnt[i] > mx) begin
        mx = cnt[i];
        cand = i;
      end
    end
    ech = 0;
    if (!m_hv || (cand != m_held && mx >= cnt[m_held] + HYST)) begin
      m_held = cand;
      ech = 1;
    end
    m_hv = 1'b1;
    eb = m_held;
    ec = cnt[m_held];
    ef = (q.size() == DEPTH) ? 1 : 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".bin_out"}, int'(bin_out), 0);
    chk({tag, ".conf"}, int'(confidence_out), 0);
    chk({tag, ".valid"}, int'(bin_valid_out), 0);
    chk({tag, ".changed"}, int'(changed_out), 0);
    chk({tag, ".full"}, int'(window_full_out), 0);
    chk({tag, ".overrun"}, int'(overrun_out), 0);
    chk({tag, ".ready"}, int'(ready_out), 1);
  endtask

  // One frame: accept b, optionally inject a dropped bin 7 at cycle inj
  // after the accept, wait for the decision and compare it.
  task automatic frame(input int b, input int eb, input int ec, input int ech,
                       input int ef, input bit use_model, input int inj,
                       input string tag);
    int lat, mb, mc, mch, mf;
    model_step(b, mb, mc, mch, mf);
    if (use_model) begin
      eb = mb; ec = mc; ech = mch; ef = mf;
    end
    chk({tag, ".ready_in"}, int'(ready_out), 1);
    bin_in = 4'(b);
    bin_valid_in = 1'b1;
    tick();
    bin_valid_in = 1'b0;
    lat = 0;
    while (!bin_valid_out && lat < 40) begin
      if (lat == inj) begin
        bin_in = 4'd7;
        bin_valid_in = 1'b1;
      end
      tick();
      bin_valid_in = 1'b0;
      lat++;
    end
    chk({tag, ".latency"}, lat, LAT);
    chk({tag, ".bin_out"}, int'(bin_out), eb);
    chk({tag, ".conf"}, int'(confidence_out), ec);
    chk({tag, ".changed"}, int'(changed_out), ech);
    chk({tag, ".full"}, int'(window_full_out), ef);
    chk({tag, ".ready_out"}, int'(ready_out), 1);
    tick();
    chk({tag, ".valid_width"}, int'(bin_valid_out), 0);
    chk({tag, ".bin_hold"}, int'(bin_out), eb);
  endtask

  initial begin
    int seen, b, d0, d1, d2, d3;

    // Fill with 5s, then wrap-around eviction by 3s.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{5, 5, i + 1, (i == 0) ? 1 : 0, (i == 7) ? 1 : 0};
    vecs[8]  = '{3, 5, 7, 0, 1};
    vecs[9]  = '{3, 5, 6, 0, 1};
    vecs[10] = '{3, 5, 5, 0, 1};
    vecs[11] = '{3, 5, 4, 0, 1};
    vecs[12] = '{3, 3, 5, 1, 1};

    // Power-on reset with a stray valid that must be ignored.
    model_reset();
    bin_valid_in = 1'b1;
    bin_in = 4'd6;
    repeat (3) tick();
    chk_reset_vals("por");
    bin_valid_in = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_reset_vals("por_rel");

    for (int i = 0; i < 13; i++) begin
      frame(vecs[i].bin, vecs[i].e_bin, vecs[i].e_conf, vecs[i].e_chg,
            vecs[i].e_full, 1'b0, -1, $sformatf("vec%0d", i));
      repeat (21) tick();
    end

    // Mid-sim reset; valid pulses during reset are ignored.
    rst_n = 1'b0;
    bin_valid_in = 1'b1;
    bin_in = 4'd1;
    #1;
    chk_reset_vals("rst_async");
    repeat (3) tick();
    chk_reset_vals("rst_hold");
    bin_valid_in = 1'b0;
    rst_n = 1'b1;
    tick();
    chk_reset_vals("rst_rel");
    model_reset();

    // Tie: 9 then 2 -> stays 9.
    frame(9, 9, 1, 1, 0, 1'b0, -1, "tie1");
    frame(2, 9, 1, 0, 0, 1'b0, -1, "tie2");

    // Overrun: dropped bin 7 three cycles after the accept.
    frame(9, 9, 2, 0, 0, 1'b0, 2, "ovr");
    chk("ovr.flag", int'(overrun_out), 1);
    // Probe hist[7]: switch to 7 must come only at the 4th 7.
    frame(7, 9, 2, 0, 0, 1'b0, -1, "probe1");
    frame(7, 9, 2, 0, 0, 1'b0, -1, "probe2");
    frame(7, 9, 2, 0, 0, 1'b0, -1, "probe3");
    frame(7, 7, 4, 1, 0, 1'b0, -1, "probe4");
    chk("ovr.sticky", int'(overrun_out), 1);

    // Reset mid-SCAN aborts the in-flight decision.
    bin_in = 4'd6;
    bin_valid_in = 1'b1;
    tick();
    bin_valid_in = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("scan_rst");
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bin_valid_out) seen++;
    end
    chk("scan_rst.no_valid", seen, 0);
    chk_reset_vals("scan_rst_after");
    model_reset();
    frame(4, 4, 1, 1, 0, 1'b0, -1, "after_rst");

    // Randomized frames against the reference model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, NUM_BINS - 1);
      else b = ($urandom_range(0, 1) == 0) ? 3 : 12;
      frame(b, d0, d1, d2, d3, 1'b1, -1, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 4)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
